l2arb: RTL

Two-requester front end for the L2 request/response interface. Arbitrates instruction-fetch and data-cache requests round-robin onto the single L2 request port through one registered output stage. Records the issuing requester of every accepted request in an in-order ID queue, then steers each L2 response back to its owner. Sits directly upstream of the L2 cache, between the L1 caches and the L2 `req_*`/`resp_*` ports.

---
 rtl/l2arb_pkg.sv | 32 +++
 rtl/l2arb_fifo.sv | 78 +++++++
 rtl/l2arb.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/l2arb_pkg.sv
// l2arb_pkg: definitions shared between the L1 caches, this arbiter and the L2.
//   - requester IDs recorded in the arbiter's in-order ID queue
//   - L2 request op encodings
//   - the registered request record that drives the L2 req_* port
package l2arb_pkg;

  localparam int ADDR_W  = 30;  // word address, byte address bits [31:2]
  localparam int WMASK_W = 4;
  localparam int WDATA_W = 32;
  localparam int RDATA_W = 64;
  localparam int OP_W    = 2;

  // Requester identity carried through the ID queue.
  localparam logic [0:0] REQ_ID_IC = 1'b0;
  localparam logic [0:0] REQ_ID_DC = 1'b1;

  // L2 request op encodings.
  localparam logic [OP_W-1:0] L2_OP_READ  = 2'b00;
  localparam logic [OP_W-1:0] L2_OP_WRITE = 2'b01;
  localparam logic [OP_W-1:0] L2_OP_FLUSH = 2'b10;
  localparam logic [OP_W-1:0] L2_OP_RSVD  = 2'b11;

  // Output stage contents (what the L2 sees on req_*).
  typedef struct packed {
    logic               valid;
    logic [OP_W-1:0]    op;
    logic [ADDR_W-1:0]  addr;
    logic [WMASK_W-1:0] wmask;
    logic [WDATA_W-1:0] wdata;
  } l2_req_t;

endpackage

// File: rtl/l2arb_fifo.sv
// l2arb_fifo: small synchronous FIFO with valid/ready on both sides.
//   wr_valid/wr_ready/wr_data : push side; wr_ready depends only on the
//                               registered occupancy (no same-cycle pop credit)
//   rd_valid/rd_ready/rd_data : pop side; rd_data is the head entry
//   count                     : registered occupancy, 0..DEPTH
// Handshake rule on every port pair: a transfer happens in a cycle where
// valid and ready are both 1 at the rising clock edge; ready never depends
// on the same side's valid.
// DEPTH must be a power of two so the pointers wrap naturally.
module l2arb_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,      // async, active-low
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_fire;
  logic             rd_fire;

  assign wr_ready = (count_q != FULL);
  assign rd_valid = (count_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    wr_fire  = wr_valid & wr_ready;
    rd_fire  = rd_valid & rd_ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Push and pop together leave the occupancy unchanged.
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/l2arb.sv
// l2arb: two-requester front end for the L2 request/response interface.
// Round-robin arbitration of instruction-fetch (IC) and data-cache (DC)
// requests into one registered output stage driving req_*; every accepted
// request's owner is queued in order so each L2 response is steered back.
//
// Ports
//   clk, rst                 : clock, async active-low reset
//   ic_req_*                 : IC read requests (op forced read, wmask/wdata 0)
//   ic_resp_*                : responses routed to IC
//   dc_req_*                 : DC requests (op/addr/wmask/wdata)
//   dc_resp_*                : responses routed to DC
//   req_*, l2_req_ready      : request port to the L2
//   l2_resp_*, resp_ready    : response port from the L2
//   arb_idle                 : output stage empty and no outstanding IDs
//
// Handshakes: every valid/ready pair transfers on a rising edge where both
// are 1. Upstream readies never depend on the same requester's valid; the
// only cross-dependency is the other requester's valid during a tie.
// The L2 returns exactly one response per accepted request, in order.
module l2arb
  import l2arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ic_req_valid,
  input  logic [ADDR_W-1:0]  ic_req_addr,
  output logic               ic_req_ready,
  output logic               ic_resp_valid,
  output logic               ic_resp_error,
  output logic [RDATA_W-1:0] ic_resp_rdata,
  input  logic               ic_resp_ready,
  input  logic               dc_req_valid,
  input  logic [OP_W-1:0]    dc_req_op,
  input  logic [ADDR_W-1:0]  dc_req_addr,
  input  logic [WMASK_W-1:0] dc_req_wmask,
  input  logic [WDATA_W-1:0] dc_req_wdata,
  output logic               dc_req_ready,
  output logic               dc_resp_valid,
  output logic               dc_resp_error,
  output logic [RDATA_W-1:0] dc_resp_rdata,
  input  logic               dc_resp_ready,
  output logic               req_valid,
  output logic [OP_W-1:0]    req_op,
  output logic [ADDR_W-1:0]  req_addr,
  output logic [WMASK_W-1:0] req_wmask,
  output logic [WDATA_W-1:0] req_wdata,
  input  logic               l2_req_ready,
  input  logic               l2_resp_valid,
  input  logic               l2_resp_error,
  input  logic [RDATA_W-1:0] l2_resp_rdata,
  output logic               resp_ready,
  output logic               arb_idle
);

  l2_req_t                ob_q, ob_d;
  logic [0:0]             last_q, last_d;   // requester granted most recently
  logic                   can_issue;
  logic                   dc_wins_tie;
  logic                   ic_fire;
  logic                   dc_fire;
  logic                   push;
  logic [0:0]             push_id;
  logic                   id_wr_ready;
  logic                   id_rd_valid;
  logic                   id_rd_ready;
  logic [0:0]             head_id;
  logic [$clog2(DEPTH):0] id_count;

  // ---------------- arbitration ----------------
  // The output stage can take a new entry if it is empty or draining this
  // cycle; the ID queue check uses the registered count only.
  assign can_issue   = (!ob_q.valid || l2_req_ready) && id_wr_ready;
  assign dc_wins_tie = (last_q == REQ_ID_IC);

  // A requester is only held off by the other one winning a tie.
  assign ic_req_ready = can_issue && !(dc_req_valid && dc_wins_tie);
  assign dc_req_ready = can_issue && !(ic_req_valid && !dc_wins_tie);

  assign ic_fire = ic_req_valid && ic_req_ready;
  assign dc_fire = dc_req_valid && dc_req_ready;
  assign push    = ic_fire || dc_fire;
  assign push_id = dc_fire ? REQ_ID_DC : REQ_ID_IC;

  always_comb begin
    ob_d   = ob_q;
    last_d = last_q;
    if (ic_fire) begin
      ob_d.valid = 1'b1;
      ob_d.op    = L2_OP_READ;
      ob_d.addr  = ic_req_addr;
      ob_d.wmask = '0;
      ob_d.wdata = '0;
      last_d     = REQ_ID_IC;
    end else if (dc_fire) begin
      ob_d.valid = 1'b1;
      ob_d.op    = dc_req_op;
      ob_d.addr  = dc_req_addr;
      ob_d.wmask = dc_req_wmask;
      ob_d.wdata = dc_req_wdata;
      last_d     = REQ_ID_DC;
    end else if (l2_req_ready) begin
      // Payload is left in place; only valid drops once the L2 takes it.
      ob_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ob_q   <= '0;
      last_q <= REQ_ID_IC;
    end else begin
      ob_q   <= ob_d;
      last_q <= last_d;
    end
  end

  assign req_valid = ob_q.valid;
  assign req_op    = ob_q.op;
  assign req_addr  = ob_q.addr;
  assign req_wmask = ob_q.wmask;
  assign req_wdata = ob_q.wdata;

  // ---------------- ID queue ----------------
  l2arb_fifo #(1, DEPTH) u_id_q (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (push),
    .wr_ready (id_wr_ready),
    .wr_data  (push_id),
    .rd_valid (id_rd_valid),
    .rd_ready (id_rd_ready),
    .rd_data  (head_id),
    .count    (id_count)
  );

  // ---------------- response steering ----------------
  // With no outstanding ID a stray L2 response is stalled, never delivered.
  assign ic_resp_valid = l2_resp_valid && id_rd_valid && (head_id == REQ_ID_IC);
  assign dc_resp_valid = l2_resp_valid && id_rd_valid && (head_id == REQ_ID_DC);
  assign ic_resp_rdata = l2_resp_rdata;
  assign dc_resp_rdata = l2_resp_rdata;
  assign ic_resp_error = l2_resp_error;
  assign dc_resp_error = l2_resp_error;

  assign resp_ready  = id_rd_valid &&
                       ((head_id == REQ_ID_DC) ? dc_resp_ready : ic_resp_ready);
  assign id_rd_ready = l2_resp_valid && resp_ready;

  assign arb_idle = !ob_q.valid && (id_count == '0);

endmodule
